// File: rtl/cla_adder_pipe.sv
// Pipelined WIDTH-bit two-level carry-lookahead adder/subtractor
// with valid/ready handshake, overflow flag and 2- or 3-stage depth.
module cla_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG = WIDTH / GROUP;

  if (WIDTH < 4 || WIDTH > 64 || GROUP < 2 || GROUP > 8 ||
      (WIDTH % GROUP) != 0 ||
      (STAGES != 2 && STAGES != 3)) begin : g_bad_param
    $error("cla_adder_pipe: illegal WIDTH/GROUP/STAGES");
  end

  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  logic [WIDTH-1:0] a_d, a_q, bb_d, bb_q;
  logic             c0_d, c0_q, v1_d, v1_q;

  always_comb begin
    a_d  = a;
    bb_d = sub ? ~b : b;
    c0_d = cin ^ sub;
    v1_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      bb_q <= '0;
      c0_q <= 1'b0;
      v1_q <= 1'b0;
    end else if (adv) begin
      a_q  <= a_d;
      bb_q <= bb_d;
      c0_q <= c0_d;
      v1_q <= v1_d;
    end
  end

  logic [WIDTH-1:0] p_d, g_d;
  logic [NG-1:0]    pg_d, gg_d;

  always_comb begin
    logic t;
    t    = 1'b0;
    p_d  = a_q ^ bb_q;
    g_d  = a_q & bb_q;
    pg_d = '0;
    gg_d = '0;
    for (int j = 0; j < NG; j++) begin
      pg_d[j] = &p_d[j*GROUP +: GROUP];
      for (int k = 0; k < GROUP; k++) begin
        t = g_d[j*GROUP+k];
        for (int m = k + 1; m < GROUP; m++)
          t = t & p_d[j*GROUP+m];
        gg_d[j] = gg_d[j] | t;
      end
    end
  end

  logic [WIDTH-1:0] fp, fg;
  logic [NG-1:0]    fpg, fgg;
  logic             fc0, fv;

  if (STAGES == 3) begin : g_mid
    logic [WIDTH-1:0] p_q, g_q;
    logic [NG-1:0]    pg_q, gg_q;
    logic             c0m_q, vm_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        p_q   <= '0;
        g_q   <= '0;
        pg_q  <= '0;
        gg_q  <= '0;
        c0m_q <= 1'b0;
        vm_q  <= 1'b0;
      end else if (adv) begin
        p_q   <= p_d;
        g_q   <= g_d;
        pg_q  <= pg_d;
        gg_q  <= gg_d;
        c0m_q <= c0_q;
        vm_q  <= v1_q;
      end
    end

    assign fp  = p_q;
    assign fg  = g_q;
    assign fpg = pg_q;
    assign fgg = gg_q;
    assign fc0 = c0m_q;
    assign fv  = vm_q;
  end else begin : g_flat
    assign fp  = p_d;
    assign fg  = g_d;
    assign fpg = pg_d;
    assign fgg = gg_d;
    assign fc0 = c0_q;
    assign fv  = v1_q;
  end

  logic [NG:0]    cg;
  logic [WIDTH:0] c;

  // Every carry is a flat sum of products; nothing ripples.
  always_comb begin
    logic t;
    t     = 1'b0;
    cg    = '0;
    c     = '0;
    cg[0] = fc0;
    for (int j = 0; j < NG; j++) begin
      t = fc0;
      for (int m = 0; m <= j; m++)
        t = t & fpg[m];
      cg[j+1] = t;
      for (int k = 0; k <= j; k++) begin
        t = fgg[k];
        for (int m = k + 1; m <= j; m++)
          t = t & fpg[m];
        cg[j+1] = cg[j+1] | t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < GROUP; k++) begin
        t = cg[j];
        for (int m = 0; m < k; m++)
          t = t & fp[j*GROUP+m];
        c[j*GROUP+k] = t;
        for (int n = 0; n < k; n++) begin
          t = fg[j*GROUP+n];
          for (int m = n + 1; m < k; m++)
            t = t & fp[j*GROUP+m];
          c[j*GROUP+k] = c[j*GROUP+k] | t;
        end
      end
    end
    c[WIDTH] = cg[NG];
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q, ov_d, ov_q;

  always_comb begin
    sum_d  = fp ^ c[WIDTH-1:0];
    cout_d = c[WIDTH];
    ovf_d  = c[WIDTH] ^ c[WIDTH-1];
    ov_d   = fv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      ov_q   <= 1'b0;
    end else if (adv) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      ov_q   <= ov_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe: 2-stage and 3-stage
// instances share stimulus; vector table plus handshake sequences.
module tb_cla_adder_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, cin, sub, out_ready;
  logic [15:0] a, b;
  logic        ir2, ov2, co2, of2;
  logic        ir3, ov3, co3, of3;
  logic [15:0] s2, s3;

  int total = 0;
  int bad   = 0;

  cla_adder_pipe #(.WIDTH(16), .GROUP(4), .STAGES(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready),
    .sum(s2), .cout(co2), .ovf(of2)
  );

  cla_adder_pipe #(.WIDTH(16), .GROUP(4), .STAGES(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov3), .out_ready(out_ready),
    .sum(s3), .cout(co3), .ovf(of3)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        of;
  } vec_t;

  vec_t vt[9];

  logic [15:0] expq[$];
  logic [15:0] hs;
  logic [15:0] ev;
  logic        held;
  int          sent, got, stalls;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
    vt[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[7] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[8] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 16'($urandom);
    b         = 16'($urandom);
    cin       = 1'($urandom);
    sub       = 1'($urandom);
    out_ready = 1'($urandom);
    tick();
    a         = 16'($urandom);
    b         = 16'($urandom);
    out_ready = 1'($urandom);
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_ov2", ov2, 0);
    chk("rst_sum2", s2, 0);
    chk("rst_co2", co2, 0);
    chk("rst_of2", of2, 0);
    chk("rst_ir2", ir2, 1);
    chk("rst_ov3", ov3, 0);
    chk("rst_sum3", s3, 0);
    chk("rst_ir3", ir3, 1);

    for (int i = 0; i < 9; i++) begin
      a        = vt[i].a;
      b        = vt[i].b;
      cin      = vt[i].cin;
      sub      = vt[i].sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lat_ov2_early", ov2, 0);
      tick();
      chk("v_ov2", ov2, 1);
      chk("v_sum2", s2, vt[i].s);
      chk("v_co2", co2, vt[i].co);
      chk("v_of2", of2, vt[i].of);
      chk("lat_ov3_early", ov3, 0);
      tick();
      chk("v_ov3", ov3, 1);
      chk("v_sum3", s3, vt[i].s);
      chk("v_co3", co3, vt[i].co);
      chk("v_of3", of3, vt[i].of);
      chk("v_ov2_once", ov2, 0);
    end

    sent   = 0;
    got    = 0;
    stalls = 0;
    held   = 1'b0;
    hs     = '0;
    cin    = 1'b0;
    sub    = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 8);
      a         = 16'(sent);
      b         = 16'(sent * 256);
      #1;
      if (held) chk("bp_hold_sum", s2, hs);
      if (ov2 && !out_ready) begin
        stalls++;
        chk("bp_ir_drop", ir2, 0);
        held = 1'b1;
        hs   = s2;
      end else begin
        chk("bp_ir_up", ir2, 1);
        held = 1'b0;
      end
      if (in_valid && ir2) begin
        expq.push_back(16'(sent * 257));
        sent++;
      end
      if (ov2 && out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bp_extra: got %0h expected none", s2);
        end else begin
          ev = expq.pop_front();
          chk("bp_sum", s2, ev);
          got++;
        end
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got, 8);
    chk("bp_stalls", stalls, 3);
    chk("bp_left", expq.size(), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_no_dup", ov2, 0);
    end

    a        = 16'h0001;
    b        = 16'h0001;
    in_valid = 1'b1;
    tick();
    a = 16'h0002;
    tick();
    chk("mr_ov3_pre", ov3, 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_ov3_rst", ov3, 0);
    chk("mr_sum3_rst", s3, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_ov3_gone", ov3, 0);
    end
    a        = 16'h0100;
    b        = 16'h0023;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mr_lat0", ov3, 0);
    tick();
    chk("mr_lat1", ov3, 0);
    tick();
    chk("mr_ov3", ov3, 1);
    chk("mr_sum3", s3, 16'h0123);
    chk("mr_co3", co3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
